// File: rtl/rng_arbiter_pkg.sv
// Shared definitions for the random-number arbiter: controller states,
// supported word widths, default seed and LFSR feedback masks.
package rng_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_SERVE  = 2'd2
   } state_t;

   localparam int OW_8  = 8;
   localparam int OW_16 = 16;
   localparam int OW_32 = 32;

   localparam logic [31:0] SEED_ALL_ONES = 32'hFFFF_FFFF;

   // Right-shift Galois masks of maximal-length polynomials, one per generator
   function automatic logic [31:0] poly_a(input int w);
      case (w)
         OW_16:   return 32'h0000_B400;
         OW_32:   return 32'h8020_0003;
         default: return 32'h0000_00B8;
      endcase
   endfunction

   function automatic logic [31:0] poly_b(input int w);
      case (w)
         OW_16:   return 32'h0000_D008;
         OW_32:   return 32'h8000_0057;
         default: return 32'h0000_008E;
      endcase
   endfunction

endpackage

// File: rtl/rng_arbiter_rng.sv
// Pair of free-running Galois LFSRs; seed_rst loads both from one seed
// (the second gets the seed with its halves swapped so the streams differ).
module rng_arbiter_rng
   import rng_arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             seed_rst,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] rnd_a,
   output logic [WIDTH-1:0] rnd_b
);

   localparam logic [31:0]      POLY_A_FULL = poly_a(WIDTH);
   localparam logic [31:0]      POLY_B_FULL = poly_b(WIDTH);
   localparam logic [WIDTH-1:0] MASK_A      = POLY_A_FULL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] MASK_B      = POLY_B_FULL[WIDTH-1:0];

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s,
                                                  input logic [WIDTH-1:0] mask);
      return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
   endfunction

   // A nonzero seed keeps both registers out of the all-zero lock-up state
   always_ff @(posedge clk) begin
      if (seed_rst) begin
         rnd_a <= seed;
         rnd_b <= {seed[WIDTH/2-1:0], seed[WIDTH-1:WIDTH/2]};
      end else begin
         rnd_a <= lfsr_step(rnd_a, MASK_A);
         rnd_b <= lfsr_step(rnd_b, MASK_B);
      end
   end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter that hands each granted requester a pair of random
// words; the generator pair is reseeded and warmed up on demand.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_SEED   | one cycle: load generators from captured seed, clear counter
//   ST_WARMUP | generators free-run for WARMUP_CYCLES, no grants
//   ST_SERVE  | one registered grant per cycle with any request pending
module rng_arbiter
   import rng_arbiter_pkg::*;
#(
   parameter int                      OUTPUT_WIDTH  = 8,
   parameter int                      NUM_REQ       = 4,
   parameter int                      WARMUP_CYCLES = 16,
   parameter logic [OUTPUT_WIDTH-1:0] SEED_DEFAULT  = SEED_ALL_ONES[OUTPUT_WIDTH-1:0]
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [OUTPUT_WIDTH-1:0] seed_in,
   input  logic                    reseed,
   input  logic [NUM_REQ-1:0]      req,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [OUTPUT_WIDTH-1:0] rnd_a,
   output logic [OUTPUT_WIDTH-1:0] rnd_b,
   output logic                    busy
);

   localparam int            PW       = $clog2(NUM_REQ);
   localparam logic [7:0]    WU_LAST  = 8'(WARMUP_CYCLES - 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

   state_t                  state;
   logic [PW-1:0]           ptr;
   logic [PW-1:0]           win_idx;
   logic [PW-1:0]           hi_idx;
   logic [PW-1:0]           lo_idx;
   logic                    hi_found;
   logic [7:0]              cnt;
   logic                    from_reset;
   logic [OUTPUT_WIDTH-1:0] seed_q;
   logic [OUTPUT_WIDTH-1:0] seed_fix;
   logic [OUTPUT_WIDTH-1:0] seed_cur;
   logic [OUTPUT_WIDTH-1:0] gen_a;
   logic [OUTPUT_WIDTH-1:0] gen_b;
   logic                    gen_rst;

   // Right after reset there is no stored seed yet, so seed_in feeds the load directly
   assign seed_fix = (seed_in == '0) ? SEED_DEFAULT : seed_in;
   assign seed_cur = from_reset ? seed_fix : seed_q;
   assign gen_rst  = (state == ST_SEED);

   rng_arbiter_rng #(
      .WIDTH (OUTPUT_WIDTH)
   ) u_rng (
      .clk      (clk),
      .seed_rst (gen_rst),
      .seed     (seed_cur),
      .rnd_a    (gen_a),
      .rnd_b    (gen_b)
   );

   // Lowest requester at or above ptr wins, otherwise the lowest overall
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      win_idx  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i[PW-1:0]]) begin
            if (i[PW-1:0] >= ptr) begin
               hi_found = 1'b1;
               hi_idx   = i[PW-1:0];
            end
            lo_idx = i[PW-1:0];
         end
      end
      win_idx = hi_found ? hi_idx : lo_idx;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_SEED;
         busy       <= 1'b1;
         gnt        <= '0;
         rnd_a      <= '0;
         rnd_b      <= '0;
         ptr        <= '0;
         cnt        <= '0;
         seed_q     <= '0;
         from_reset <= 1'b1;
      end else begin
         gnt        <= '0;
         rnd_a      <= '0;
         rnd_b      <= '0;
         from_reset <= 1'b0;
         if (reseed) begin
            state  <= ST_SEED;
            busy   <= 1'b1;
            seed_q <= seed_fix;
         end else begin
            case (state)
               ST_SEED: begin
                  state <= ST_WARMUP;
                  cnt   <= '0;
               end
               ST_WARMUP: begin
                  cnt <= cnt + 1'b1;
                  if (cnt == WU_LAST) begin
                     state <= ST_SERVE;
                     busy  <= 1'b0;
                  end
               end
               ST_SERVE: begin
                  if (|req) begin
                     gnt   <= NUM_REQ'(1) << win_idx;
                     rnd_a <= gen_a;
                     rnd_b <= gen_b;
                     ptr   <= (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
                  end
               end
               default: begin
                  state <= ST_SEED;
                  busy  <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter: directed vectors, corner sequences and
// a randomized run compared against a cycle-count based reference model.
module tb_rng_arbiter;

   localparam int         W      = 8;
   localparam int         N      = 4;
   localparam int         WU     = 16;
   localparam logic [W-1:0] MASK_A = 8'hB8;
   localparam logic [W-1:0] MASK_B = 8'h8E;

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] exp_gnt;
   } vec_t;

   logic         clk     = 1'b0;
   logic         reset   = 1'b0;
   logic         reseed  = 1'b0;
   logic [W-1:0] seed_in = '0;
   logic [N-1:0] req     = '0;
   logic [N-1:0] gnt;
   logic [W-1:0] rnd_a;
   logic [W-1:0] rnd_b;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state: edges since reset release, edge at which serving
   // starts, edge at which the generators were loaded, next search start
   int           ecount;
   int           m_ready;
   int           m_load;
   int           m_ptr;
   logic [W-1:0] m_seed;
   logic [N-1:0] exp_gnt;
   logic [W-1:0] exp_a;
   logic [W-1:0] exp_b;
   logic         exp_busy;

   logic [W-1:0] run_a [3][12];
   logic [W-1:0] run_b [3][12];
   vec_t         tbl [13];

   rng_arbiter #(
      .OUTPUT_WIDTH  (W),
      .NUM_REQ       (N),
      .WARMUP_CYCLES (WU)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .seed_in (seed_in),
      .reseed  (reseed),
      .req     (req),
      .gnt     (gnt),
      .rnd_a   (rnd_a),
      .rnd_b   (rnd_b),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got no summary, required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] fix_seed(input logic [W-1:0] s);
      return (s == '0) ? {W{1'b1}} : s;
   endfunction

   function automatic logic [W-1:0] lfsr_after(input logic [W-1:0] s,
                                               input logic [W-1:0] mask, input int n);
      logic [W-1:0] v;
      v = s;
      for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ mask) : (v >> 1);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, exp, ecount);
      end
   endtask

   task automatic chk_ne(input string name, input logic [31:0] act, input logic [31:0] avoid);
      n_checks++;
      if (act === avoid) begin
         n_fail++;
         $display("FAIL %s: got %0h, required anything but %0h (edge %0d)", name, act, avoid, ecount);
      end
   endtask

   // Predicts outputs for the coming edge from current inputs, clocks, compares
   task automatic tick();
      int e;
      int win;
      bit found;
      e       = ecount + 1;
      exp_gnt = '0;
      exp_a   = '0;
      exp_b   = '0;
      if (reseed) begin
         m_seed  = fix_seed(seed_in);
         m_load  = e + 1;
         m_ready = e + WU + 2;
      end else begin
         if (e == 1) m_seed = fix_seed(seed_in);
         if (e >= m_ready && req != '0) begin
            found = 1'b0;
            win   = 0;
            for (int k = 0; k < N; k++) begin
               int i;
               i = (m_ptr + k) % N;
               if (!found && ((req >> i) & N'(1)) != '0) begin
                  found = 1'b1;
                  win   = i;
               end
            end
            exp_gnt = N'(1) << win;
            m_ptr   = (win + 1) % N;
            exp_a   = lfsr_after(m_seed, MASK_A, e - 1 - m_load);
            exp_b   = lfsr_after({m_seed[W/2-1:0], m_seed[W-1:W/2]}, MASK_B, e - 1 - m_load);
         end
      end
      exp_busy = (e < m_ready - 1);
      @(posedge clk);
      #1;
      ecount = e;
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("rnd_a", 32'(rnd_a), 32'(exp_a));
      chk("rnd_b", 32'(rnd_b), 32'(exp_b));
      chk("busy", 32'(busy), 32'(exp_busy));
   endtask

   task automatic do_reset(input logic [W-1:0] s);
      @(negedge clk);
      reset   = 1'b0;
      reseed  = 1'b0;
      req     = '0;
      seed_in = s;
      #1;
      chk("rst_gnt", 32'(gnt), 32'(0));
      chk("rst_rnd_a", 32'(rnd_a), 32'(0));
      chk("rst_rnd_b", 32'(rnd_b), 32'(0));
      chk("rst_busy", 32'(busy), 32'(1));
      @(negedge clk);
      @(negedge clk);
      reset   = 1'b1;
      ecount  = 0;
      m_ready = WU + 2;
      m_load  = 1;
      m_ptr   = 0;
   endtask

   task automatic wait_serve(input string name);
      int k;
      k = 0;
      while (busy && k < 40) begin
         tick();
         k++;
      end
      chk(name, 32'(busy), 32'(0));
   endtask

   task automatic capture(input int r, input logic [W-1:0] s);
      do_reset(s);
      wait_serve("capture_warmup");
      req = 4'b1111;
      for (int j = 0; j < 12; j++) begin
         tick();
         run_a[r][j] = rnd_a;
         run_b[r][j] = rnd_b;
      end
      req = '0;
   endtask

   initial begin
      int n;
      int zeros;
      bit got;
      int diffs;
      logic [W-1:0] prev_a;
      logic [N-1:0] pend;

      tbl[0]  = '{4'b1111, 4'b0001};
      tbl[1]  = '{4'b1111, 4'b0010};
      tbl[2]  = '{4'b1111, 4'b0100};
      tbl[3]  = '{4'b1111, 4'b1000};
      tbl[4]  = '{4'b1111, 4'b0001};
      tbl[5]  = '{4'b0000, 4'b0000};
      tbl[6]  = '{4'b1001, 4'b1000};
      tbl[7]  = '{4'b1001, 4'b0001};
      tbl[8]  = '{4'b0110, 4'b0010};
      tbl[9]  = '{4'b0001, 4'b0001};
      tbl[10] = '{4'b1100, 4'b0100};
      tbl[11] = '{4'b0011, 4'b0001};
      tbl[12] = '{4'b0000, 4'b0000};

      // busy window after reset release
      do_reset(8'h5A);
      n = busy ? 1 : 0;
      while (busy && n < 40) begin
         tick();
         if (busy) n++;
      end
      chk("busy_len", 32'(n), 32'(17));

      // round-robin vectors; rnd_a must move on every back-to-back grant
      prev_a = '0;
      for (int r = 0; r < 13; r++) begin
         req = tbl[r].req;
         tick();
         chk("table_gnt", 32'(gnt), 32'(tbl[r].exp_gnt));
         if (r >= 1 && r <= 4) chk_ne("rnd_a_moves", 32'(rnd_a), 32'(prev_a));
         prev_a = rnd_a;
      end
      req = '0;

      // reseed together with a request: request waits out the warm-up
      seed_in = 8'h5A;
      req     = 4'b0100;
      reseed  = 1'b1;
      tick();
      reseed = 1'b0;
      chk("reseed_suppress", 32'(gnt), 32'(0));
      zeros = 0;
      got   = 1'b0;
      while (!got && zeros < 40) begin
         tick();
         if (gnt != '0) got = 1'b1;
         else zeros++;
      end
      chk("reseed_gap", 32'(zeros), 32'(17));
      chk("reseed_gnt", 32'(gnt), 32'(4'b0100));
      req = '0;

      // zero seed falls back to the default seed
      seed_in = '0;
      reseed  = 1'b1;
      tick();
      reseed = 1'b0;
      wait_serve("zero_seed_warmup");
      req = 4'b0001;
      tick();
      req = '0;
      chk("zero_seed_gnt", 32'(gnt), 32'(4'b0001));
      chk_ne("zero_seed_rnd_a", 32'(rnd_a), 32'(0));

      // repeatability across identical runs, divergence with another seed
      capture(0, 8'hC3);
      capture(1, 8'hC3);
      capture(2, 8'h3C);
      diffs = 0;
      for (int j = 0; j < 12; j++)
         if (run_a[0][j] !== run_a[1][j] || run_b[0][j] !== run_b[1][j]) diffs++;
      chk("same_seed_repeat", 32'(diffs), 32'(0));
      diffs = 0;
      for (int j = 0; j < 12; j++)
         if (run_a[0][j] !== run_a[2][j] || run_b[0][j] !== run_b[2][j]) diffs++;
      chk_ne("other_seed_differs", 32'(diffs), 32'(0));

      // reset mid-grant clears outputs without waiting for a clock edge
      do_reset(8'h77);
      wait_serve("midreset_warmup");
      req = 4'b1111;
      tick();
      chk_ne("midreset_pre_gnt", 32'(gnt), 32'(0));
      #2;
      reset = 1'b0;
      #1;
      chk("midreset_gnt", 32'(gnt), 32'(0));
      chk("midreset_rnd_a", 32'(rnd_a), 32'(0));
      chk("midreset_rnd_b", 32'(rnd_b), 32'(0));
      chk("midreset_busy", 32'(busy), 32'(1));

      // randomized traffic with occasional reseeds
      do_reset(W'($urandom));
      pend = '0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 2) == 0) pend = pend | N'($urandom);
         req    = pend;
         reseed = ($urandom_range(0, 59) == 0);
         seed_in = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
         tick();
         reseed = 1'b0;
         pend   = pend & ~gnt;
      end
      req = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rng_arbiter.md
RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 Parameter OUTPUT_WIDTH, default 8, width of each random word; legal values 8, 16, 32.
REQ-002 Parameter NUM_REQ, default 4, number of requesters; legal range 2..8.
REQ-003 Parameter WARMUP_CYCLES, default 16, discarded LFSR steps after every seed load; legal range 1..255.
REQ-004 Parameter SEED_DEFAULT, default all-ones, substitute seed used when the captured seed is zero.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 seed_in  input  OUTPUT_WIDTH  seed value, sampled only when a seed load is initiated.
REQ-008 reseed  input  1  one-cycle request to reload both generators from seed_in.
REQ-009 req  input  NUM_REQ  per-requester request; each requester holds its bit high until it sees its gnt bit.
REQ-010 gnt  output  NUM_REQ  one-hot grant, high for exactly one cycle per served request.
REQ-011 rnd_a  output  OUTPUT_WIDTH  first random word, valid in the gnt cycle only.
REQ-012 rnd_b  output  OUTPUT_WIDTH  second random word, valid in the gnt cycle only.
REQ-013 busy  output  1  high in SEED and WARMUP states.

Function
REQ-014 FSM states: SEED, WARMUP, SERVE.
REQ-015 SEED lasts 1 cycle.
- Drives the internal generator pair's reset with the captured seed.
- Clears the warm-up counter.
- Next state is WARMUP.
REQ-016 Seed capture:
- The seed is captured from seed_in on the reset-release cycle and on each accepted reseed.
- A captured value of zero is replaced by SEED_DEFAULT.
REQ-017 WARMUP:
- The generators free-run while the counter increments.
- The state moves to SERVE once WARMUP_CYCLES cycles have elapsed.
- No grants are issued.
REQ-018 SERVE behaviour:
- Each cycle with any req bit high, the arbiter issues exactly one grant on the next cycle (1-cycle registered latency).
- rnd_a and rnd_b are registered copies of the generator outputs from the arbitration cycle.
REQ-019 Arbitration is round-robin.
- Search order starts at the index after the last granted requester and wraps from NUM_REQ-1 to 0.
- The pointer resets to 0.
- The pointer is preserved across reseeds.
REQ-020 Back-to-back grants are permitted every cycle.
- A requester whose req is still high one cycle after its gnt is treated as a new request.
- The requester drops req in the gnt cycle to avoid this.
REQ-021 Consecutive grants always carry words from distinct LFSR steps, because the generators advance every clock.
REQ-022 reseed in SERVE:
- Transitions to SEED next cycle.
- Suppresses any grant that would have been issued for that cycle's arbitration.
REQ-023 reseed in SEED or WARMUP re-enters SEED with the newly captured seed, restarting warm-up.
REQ-024 When reseed and req are high in the same cycle, reseed wins; the requests stay pending and are served after WARMUP.
REQ-025 gnt, rnd_a and rnd_b are zero in every cycle without a grant.

Reset
REQ-026 While reset is low, the block holds the following values:
- State = SEED.
- gnt = 0, rnd_a = 0, rnd_b = 0.
- busy = 1.
- Pointer = 0, counter = 0.
REQ-027 The first rising clk edge after reset deasserts performs the SEED actions with seed_in.
REQ-028 Reset assertion mid-operation aborts any pending grant immediately, with no partial output.

Structure
REQ-029 A shared package holds:
- The FSM state enum.
- The legal OUTPUT_WIDTH values.
- The SEED_DEFAULT constant.
REQ-030 One sub-module, rng, provides the two generators.
- Its synchronous active-high reset is driven by the controller as the SEED-state pulse.
- It is not tied directly to the block reset.
REQ-031 Arbiter pointer logic, warm-up counter and FSM reside in rng_arbiter.

Verification
REQ-032 Reset release with seed_in=8'h5A and req held 0 -> busy=1 for 17 cycles (SEED + 16 WARMUP), then 0; gnt stays 0.
REQ-033 In SERVE, req=4'b1111 held continuously -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with rnd_a differing each cycle.
REQ-034 seed_in=0 with reseed pulse -> the generator pair is loaded with SEED_DEFAULT; rnd_a is nonzero on the first post-warm-up grant.
REQ-035 reseed and req=4'b0100 in the same SERVE cycle -> no gnt for 17 cycles, then gnt=4'b0100.
REQ-036 Two runs with identical seed 8'hC3 and identical req pattern -> bit-identical rnd_a/rnd_b sequences; a different seed -> the sequences differ.
REQ-037 reset asserted low mid-SERVE with req pending -> gnt, rnd_a and rnd_b are 0 immediately, before the next clk edge.
